// File: rtl/power_pkg.sv
`default_nettype none
// ============================================================================
// Module      : power_pkg
// Description : Shared constants for the power pipeline and its result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package power_pkg;

    // Width of a power pipeline result word.
    localparam int POWER_DATA_WIDTH = 64;

    // Cycles from operand issue to result strobe in the power pipeline.
    localparam int POWER_LATENCY = 3;

endpackage : power_pkg
`default_nettype wire

// File: rtl/power_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : power_fifo_mem
// Description : Simple dual-port register file, synchronous write,
//               asynchronous read, contents not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module power_fifo_mem
    import power_pkg::*;
#(
    parameter int DATA_WIDTH = POWER_DATA_WIDTH,
    parameter int ENTRIES    = 7,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [ENTRIES];

    // Write port: one entry per cycle on the rising edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port is combinational so the head is ready for the output stage.
    assign o_rdata = r_mem[i_raddr];

endmodule : power_fifo_mem
`default_nettype wire

// File: rtl/power_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : power_result_fifo
// Description : Result buffer behind the power pipeline. Valid-only input,
//               valid/ready output through a registered head stage, early
//               almost-full for the issuer, sticky overflow on dropped results.
//               Optional macro POWER_RESULT_FIFO_DROP_CNT_EN adds a saturating
//               16-bit dropped-result counter on o_drop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module power_result_fifo
    import power_pkg::*;
#(
    parameter int DATA_WIDTH   = POWER_DATA_WIDTH,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = POWER_LATENCY
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic                    o_almost_full,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    input  logic                    i_ready,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow
`ifdef POWER_RESULT_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]             o_drop_cnt
`endif
);

    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int PTR_W     = $clog2(RAM_DEPTH);

    localparam logic [CNT_W-1:0] c_full_count   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_afull_thresh = CNT_W'(DEPTH - AFULL_MARGIN);
    localparam logic [PTR_W-1:0] c_ptr_last     = PTR_W'(RAM_DEPTH - 1);

    // RAM depth is DEPTH-1, not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == c_ptr_last) ? '0 : ptr + 1'b1;
    endfunction

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_ram_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_afull;
    logic                  r_overflow;

    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_ram_empty;
    logic                  w_push_to_out;
    logic                  w_push_to_ram;
    logic                  w_ram_to_out;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic [CNT_W-1:0]      w_count_next;
    logic [CNT_W-1:0]      w_ram_cnt_next;

    // Handshake decode and routing of the incoming word.
    always_comb begin
        w_pop         = r_out_valid && i_ready;
        w_full        = (r_count == c_full_count);
        w_push        = i_valid && (!w_full || w_pop);
        w_drop        = i_valid && w_full && !w_pop;
        w_ram_empty   = (r_ram_cnt == '0);
        // The head register takes the new word directly whenever the RAM
        // holds nothing older; otherwise the word queues behind the RAM.
        w_push_to_out = w_push && (!r_out_valid || (w_pop && w_ram_empty));
        w_push_to_ram = w_push && !w_push_to_out;
        w_ram_to_out  = w_pop && !w_ram_empty;
    end

    // Next occupancy values: total and RAM-only.
    always_comb begin
        w_count_next   = r_count;
        w_ram_cnt_next = r_ram_cnt;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
        case ({w_push_to_ram, w_ram_to_out})
            2'b10:   w_ram_cnt_next = r_ram_cnt + 1'b1;
            2'b01:   w_ram_cnt_next = r_ram_cnt - 1'b1;
            default: w_ram_cnt_next = r_ram_cnt;
        endcase
    end

    power_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (RAM_DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push_to_ram),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    // Pointers, occupancy counters and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ram_cnt  <= '0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_to_ram) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_ram_to_out) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            r_count   <= w_count_next;
            r_ram_cnt <= w_ram_cnt_next;
            // Looks at the registered count so the flag trails it by a cycle.
            r_afull   <= (r_count >= c_afull_thresh);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output stage: RAM head has priority, since it is older than i_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_ram_to_out) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ram_rdata;
            end else if (w_push_to_out) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_data;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef POWER_RESULT_FIFO_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of dropped results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_valid       = r_out_valid;
    assign o_data        = r_out_data;
    assign o_count       = r_count;
    assign o_almost_full = r_afull;
    assign o_overflow    = r_overflow;

endmodule : power_result_fifo
`default_nettype wire

// File: tb/tb_power_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_result_fifo
// Description : Directed self-checking bench for power_result_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_result_fifo;

    logic        clk;
    logic        reset_n;
    logic        i_valid;
    logic [63:0] i_data;
    logic        o_almost_full;
    logic        o_valid;
    logic [63:0] o_data;
    logic        i_ready;
    logic [3:0]  o_count;
    logic        o_overflow;
`ifdef POWER_RESULT_FIFO_DROP_CNT_EN
    logic [15:0] o_drop_cnt;
`endif

    int total;
    int bad;

    power_result_fifo dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_almost_full (o_almost_full),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .i_ready       (i_ready),
        .o_count       (o_count),
        .o_overflow    (o_overflow)
`ifdef POWER_RESULT_FIFO_DROP_CNT_EN
        ,
        .o_drop_cnt    (o_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
        total++; if (o_data !== 64'h0) begin bad++; $display("FAIL rst_data got=%0h exp=0", o_data); end
        total++; if (o_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", o_count); end
        total++; if (o_almost_full !== 1'b0) begin bad++; $display("FAIL rst_afull got=%0b exp=0", o_almost_full); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0b exp=0", o_overflow); end
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pass_through();
        do_reset();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 64'h100;
        tick();
        i_valid = 1'b0;
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL pt_valid got=%0b exp=1", o_valid); end
        total++; if (o_data !== 64'h100) begin bad++; $display("FAIL pt_data got=%0h exp=100", o_data); end
        total++; if (o_count !== 4'd1) begin bad++; $display("FAIL pt_count got=%0d exp=1", o_count); end
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pt_valid_after got=%0b exp=0", o_valid); end
        total++; if (o_count !== 4'd0) begin bad++; $display("FAIL pt_count_after got=%0d exp=0", o_count); end
        i_ready = 1'b0;
    endtask

    task automatic test_fill_drop();
        logic [3:0] exp_cnt;
        do_reset();
        i_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            i_valid = 1'b1;
            i_data  = 64'(k);
            tick();
            exp_cnt = (k <= 8) ? 4'(k) : 4'd8;
            total++; if (o_count !== exp_cnt) begin bad++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, o_count, exp_cnt); end
            total++; if (o_almost_full !== (k >= 6)) begin bad++; $display("FAIL fill_afull k=%0d got=%0b exp=%0b", k, o_almost_full, (k >= 6)); end
            total++; if (o_overflow !== (k == 9)) begin bad++; $display("FAIL fill_overflow k=%0d got=%0b exp=%0b", k, o_overflow, (k == 9)); end
        end
        i_valid = 1'b0;
        tick();
        total++; if (o_count !== 4'd8) begin bad++; $display("FAIL fill_hold_count got=%0d exp=8", o_count); end
        i_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            total++; if (o_valid !== 1'b1 || o_data !== 64'(j)) begin bad++; $display("FAIL drain_data j=%0d got=%0h/%0b exp=%0h/1", j, o_data, o_valid, j); end
            tick();
        end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b exp=0", o_valid); end
        total++; if (o_count !== 4'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", o_count); end
        total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%0b exp=1", o_overflow); end
        i_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [63:0] exp_d;
        do_reset();
        i_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            i_valid = 1'b1;
            i_data  = 64'(k);
            tick();
        end
        i_valid = 1'b1;
        i_data  = 64'hA;
        i_ready = 1'b1;
        total++; if (o_data !== 64'h1) begin bad++; $display("FAIL fpp_head got=%0h exp=1", o_data); end
        tick();
        i_valid = 1'b0;
        total++; if (o_count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d exp=8", o_count); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%0b exp=0", o_overflow); end
        for (int j = 2; j <= 9; j++) begin
            exp_d = (j == 9) ? 64'hA : 64'(j);
            total++; if (o_valid !== 1'b1 || o_data !== exp_d) begin bad++; $display("FAIL fpp_drain j=%0d got=%0h exp=%0h", j, o_data, exp_d); end
            tick();
        end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%0b exp=0", o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_wrap_stall();
        int          sent;
        int          rcv;
        int          cyc;
        logic        stalled;
        logic [63:0] held;
        do_reset();
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        while (rcv < 40 && cyc < 2000) begin
            i_valid = (sent < 40) && !o_almost_full && ($urandom_range(0, 3) != 0);
            i_data  = 64'h1000 + 64'(sent);
            i_ready = ($urandom_range(0, 1) == 1);
            if (o_valid && i_ready) begin
                total++; if (o_data !== 64'h1000 + 64'(rcv)) begin bad++; $display("FAIL wrap_order n=%0d got=%0h exp=%0h", rcv, o_data, 64'h1000 + 64'(rcv)); end
                rcv++;
            end
            stalled = o_valid && !i_ready;
            held    = o_data;
            if (i_valid) sent++;
            tick();
            if (stalled) begin
                total++; if (o_valid !== 1'b1 || o_data !== held) begin bad++; $display("FAIL wrap_stall got=%0h/%0b exp=%0h/1", o_data, o_valid, held); end
            end
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        total++; if (rcv != 40) begin bad++; $display("FAIL wrap_timeout got=%0d exp=40", rcv); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL wrap_overflow got=%0b exp=0", o_overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1;
            i_data  = 64'h20 + 64'(k);
            tick();
        end
        i_valid = 1'b0;
        total++; if (o_count !== 4'd4) begin bad++; $display("FAIL mid_pre_count got=%0d exp=4", o_count); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", o_valid); end
        total++; if (o_data !== 64'h0) begin bad++; $display("FAIL mid_data got=%0h exp=0", o_data); end
        total++; if (o_count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", o_count); end
        total++; if (o_almost_full !== 1'b0) begin bad++; $display("FAIL mid_afull got=%0b exp=0", o_almost_full); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%0b exp=0", o_overflow); end
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_data  = 64'h5;
        tick();
        i_valid = 1'b0;
        total++; if (o_valid !== 1'b1 || o_data !== 64'h5) begin bad++; $display("FAIL mid_push got=%0h/%0b exp=5/1", o_data, o_valid); end
        total++; if (o_count !== 4'd1) begin bad++; $display("FAIL mid_push_count got=%0d exp=1", o_count); end
    endtask

`ifdef POWER_RESULT_FIFO_DROP_CNT_EN
    task automatic test_drop_cnt();
        do_reset();
        i_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            i_valid = 1'b1;
            i_data  = 64'(k);
            tick();
        end
        total++; if (o_drop_cnt !== 16'd0) begin bad++; $display("FAIL dcnt_zero got=%0d exp=0", o_drop_cnt); end
        repeat (3) tick();
        total++; if (o_drop_cnt !== 16'd3) begin bad++; $display("FAIL dcnt_three got=%0d exp=3", o_drop_cnt); end
        repeat (65537) tick();
        i_valid = 1'b0;
        total++; if (o_drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL dcnt_sat got=%0h exp=ffff", o_drop_cnt); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_pass_through();
        test_fill_drop();
        test_full_push_pop();
        test_wrap_stall();
        test_reset_mid();
`ifdef POWER_RESULT_FIFO_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_power_result_fifo
`default_nettype wire

// File: doc/power_result_fifo.md
# power_result_fifo

Downstream buffer for the `power` pipeline. It captures the 64-bit valid-only result stream (`o_valid`/`o_data` of `power`) into a small FIFO and presents it to consumers over a valid/ready handshake. Because the `power` pipeline has no backpressure, the block raises a registered almost-full flag early enough for the upstream issuer to stop feeding new operands before results are lost. It also reports any dropped result.

## Interface
- `DATA_WIDTH`, default 64: result width; matches the `power` output.
- `DEPTH`, default 8: total capacity in entries, output register included. Power of 2, ≥4.
- `AFULL_MARGIN`, default 3: slots reserved for results already in flight in `power` (its latency).
- `clk`  in  1  clock; all state on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  result strobe from `power.o_valid`.
- `i_data`  in  DATA_WIDTH  result from `power.o_data`.
- `o_almost_full`  out  1  upstream must stop issuing `i_valid` into `power` while high.
- `o_valid`  out  1  head entry available.
- `o_data`  out  DATA_WIDTH  head entry.
- `i_ready`  in  1  consumer accepts head.
- `o_count`  out  $clog2(DEPTH)+1  entries held.
- `o_overflow`  out  1  sticky; a result was dropped.

## Operation
- Storage:
  - RAM of DEPTH-1 entries with wrap-around read/write pointers.
  - A registered output stage holds the head entry. `o_valid` and `o_data` come directly from flops.
- Pop: occurs when `o_valid && i_ready`.
- Push accepted: when `i_valid && (o_count < DEPTH || pop)`. Simultaneous push and pop while full is legal. Count stays at DEPTH; no drop.
- Push dropped:
  - Occurs when `i_valid && o_count == DEPTH && !pop`.
  - Data is discarded and `o_overflow` is set.
  - `o_overflow` is cleared only by reset.
- Routing of a pushed word:
  - Goes into the output register if that register is empty, or is being popped while the RAM is empty.
  - Otherwise it is written to the RAM.
  - On pop with a non-empty RAM, the RAM head loads the output register.
- Ordering: strict FIFO at all times, including across pointer wrap.
- Count: `o_count` = output register occupancy + RAM occupancy. It changes by +1 (push only), −1 (pop only) or 0 (both or neither).
- Almost-full: `o_almost_full` is registered and is high in the cycle after `o_count` becomes ≥ DEPTH−AFULL_MARGIN.
- Consumer-side rules:
  - `o_data` is stable while `o_valid && !i_ready`.
  - `o_valid` never deasserts without a pop.
- Reset:
  - Asynchronous clear of pointers, count, output register valid, `o_overflow` and `o_almost_full`.
  - Stored data is lost.
  - Reset values: `o_valid`=0, `o_data`=0, `o_count`=0, `o_almost_full`=0, `o_overflow`=0.

## Timing
- Latency: a push into an empty block gives `o_valid`=1 with that data on the next rising edge.
- Throughput: one push and one pop per cycle, sustained.
- `o_count`, `o_almost_full` and `o_overflow` update one cycle after the causing event.
- Combinational paths: none from inputs to outputs. `i_ready` only affects next-state logic.
- Reset mid-transfer: outputs go to reset values immediately (asynchronously). The first push after release behaves as a push into empty.

## Configuration
- Macro: `POWER_RESULT_FIFO_DROP_CNT_EN`.
- Defined:
  - Adds output `o_drop_cnt`, 16 bits.
  - It increments on every dropped push and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: port and counter are absent. `o_overflow` is the only drop indication.

## Structure
- Shared package `power_pkg`:
  - `POWER_DATA_WIDTH` = 64.
  - `POWER_LATENCY` = 3, used as the `AFULL_MARGIN` default and by `power`.
- Sub-module `power_fifo_mem`:
  - Simple dual-port register file, DEPTH-1 × DATA_WIDTH.
  - Synchronous write, asynchronous read, no reset on contents.
- Pointer, count, output-stage and flag logic stay in `power_result_fifo`.

## Test plan
- Single pass-through: one push of 64'h100 with `i_ready`=1 → next cycle `o_valid`=1, `o_data`=64'h100. One cycle later `o_valid`=0 and `o_count`=0.
- Fill and drop: `i_ready`=0, push 64'h1..64'h9 on consecutive cycles:
  - `o_almost_full` is high the cycle after `o_count`=5.
  - `o_count` saturates at 8; value 9 is dropped and `o_overflow`=1.
  - Draining returns 64'h1..64'h8 in order.
- Full plus simultaneous push/pop: with 8 entries, push 64'hA while `i_ready`=1 → `o_count` stays 8, no overflow, and 64'hA is read out last.
- Wrap and stall: 40 pushes of an incrementing pattern against random `i_ready` (~50%) → all values received in order, no overflow, `o_data` stable during every stall.
- Reset mid-operation: with 4 entries held, pulse `reset_n` low mid-cycle → `o_valid`, `o_count`, `o_almost_full` and `o_overflow` read 0 immediately. A following push of 64'h5 appears one cycle later.
- Macro on: 3 dropped pushes while full → `o_drop_cnt`=3. With the counter preset near max via 65 540 drops, it holds at 16'hFFFF.
